// File: rtl/memory_bank.sv
// -----------------------------------------------------------------------------
// MemoryBank: single-port word-addressed memory with byte-enabled writes and
// a programmable number of wait states per access.
//
// A request (read, write, or both) is accepted from IDLE, held in internal
// registers, and completed WAIT_STATES+1 edges later. Completion is signalled
// with a one-cycle o_done pulse. o_busy is high for the whole in-flight
// window, and new requests are ignored while it is high.
//
// Parameters
//   ADDR_WIDTH  : word address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  : word width, must be a multiple of 8
//   WAIT_STATES : extra access cycles before completion, 0..255
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset (memory contents kept)
//   i_addr     : word address
//   i_read     : read request
//   i_write    : write request
//   i_bytesel  : write byte enables, bit k covers i_data[8k+7:8k]
//   i_data     : write data
//   o_data     : registered read data
//   o_busy     : registered, high while a request is in flight
//   o_done     : registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module memory_bank #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [DATA_WIDTH/8-1:0] i_bytesel,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  // Parameter sanity checks, caught at elaboration time.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH <= 0) begin : gBadDataWidth
    $error("memory_bank: DATA_WIDTH must be a positive multiple of 8");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : gBadWaitStates
    $error("memory_bank: WAIT_STATES must be in 0..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                  state_q,   state_d;
  logic [7:0]              waitCnt_q, waitCnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]   wrData_q,  wrData_d;
  logic [NUM_BYTES-1:0]    byteSel_q, byteSel_d;
  logic                    rdFlag_q,  rdFlag_d;
  logic                    wrFlag_q,  wrFlag_d;
  logic [DATA_WIDTH-1:0]   rdData_q,  rdData_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;

  logic                    accessNow;
  logic                    memWe;
  logic [DATA_WIDTH-1:0]   memWord;

  // Storage array. It has no reset so that its contents survive a reset.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // The access happens on the edge that leaves WAIT with the counter at zero.
  // While reset is high the state is IDLE, so an aborted request can never
  // reach memory.
  assign accessNow = (state_q == WAIT) && (waitCnt_q == 8'd0);
  assign memWe     = accessNow && wrFlag_q;
  assign memWord   = mem_q[addr_q];

  // Next-state logic: accept a request from IDLE, count down the wait states,
  // then complete. The read samples the word before the same-edge write lands,
  // which gives read-before-write for combined requests.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    wrData_d  = wrData_q;
    byteSel_d = byteSel_q;
    rdFlag_d  = rdFlag_q;
    wrFlag_d  = wrFlag_q;
    rdData_d  = rdData_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_read || i_write) begin
          addr_d    = i_addr;
          wrData_d  = i_data;
          byteSel_d = i_bytesel;
          rdFlag_d  = i_read;
          wrFlag_d  = i_write;
          waitCnt_d = WAIT_INIT;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q != 8'd0) begin
          waitCnt_d = waitCnt_q - 8'd1;
        end else begin
          if (rdFlag_q) begin
            rdData_d = memWord;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WAIT);
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      wrData_q  <= '0;
      byteSel_q <= '0;
      rdFlag_q  <= 1'b0;
      wrFlag_q  <= 1'b0;
      rdData_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      wrData_q  <= wrData_d;
      byteSel_q <= byteSel_d;
      rdFlag_q  <= rdFlag_d;
      wrFlag_q  <= wrFlag_d;
      rdData_q  <= rdData_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Byte-enabled memory write using the latched request fields only.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (byteSel_q[k]) begin
          mem_q[addr_q][8*k +: 8] <= wrData_q[8*k +: 8];
        end
      end
    end
  end

  assign o_data = rdData_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_memory_bank.sv
// -----------------------------------------------------------------------------
// Testbench for memory_bank. Two instances run side by side on one clock:
// dut0 with no wait states and dut3 with three. Inputs are driven and outputs
// sampled on the falling edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_bank;

  logic        clk = 1'b0;
  logic        reset;

  logic [19:0] addr0, addr3;
  logic        rd0, wr0, rd3, wr3;
  logic [3:0]  bsel0, bsel3;
  logic [31:0] data0, data3;
  logic [31:0] odata0, odata3;
  logic        busy0, busy3, done0, done3;

  int checks = 0;
  int passes = 0;

  memory_bank #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .i_addr(addr0), .i_read(rd0), .i_write(wr0),
    .i_bytesel(bsel0), .i_data(data0), .o_data(odata0), .o_busy(busy0), .o_done(done0)
  );

  memory_bank #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .i_addr(addr3), .i_read(rd3), .i_write(wr3),
    .i_bytesel(bsel3), .i_data(data3), .o_data(odata3), .o_busy(busy3), .o_done(done3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Drives the request inputs of the selected instance (0 or 3).
  task automatic applyStimulus(input int unit, input logic rd, input logic wr,
                               input logic [19:0] addr, input logic [31:0] data,
                               input logic [3:0] bsel);
    if (unit == 0) begin
      rd0 = rd; wr0 = wr; addr0 = addr; data0 = data; bsel0 = bsel;
    end else begin
      rd3 = rd; wr3 = wr; addr3 = addr; data3 = data; bsel3 = bsel;
    end
  endtask

  function automatic logic getDone(input int unit);
    return (unit == 0) ? done0 : done3;
  endfunction

  function automatic logic getBusy(input int unit);
    return (unit == 0) ? busy0 : busy3;
  endfunction

  function automatic logic [31:0] getData(input int unit);
    return (unit == 0) ? odata0 : odata3;
  endfunction

  // Issues one request at the current falling edge, drops it after one cycle,
  // then waits (bounded) for o_done. Checks completion, latency counted in
  // falling edges from the issue point (2 + wait states), busy low in the
  // done cycle, and optionally o_data. Returns in the o_done cycle.
  task automatic runAccess(input int unit, input logic rd, input logic wr,
                           input logic [19:0] addr, input logic [31:0] data,
                           input logic [3:0] bsel, input string tag,
                           input logic [31:0] expData, input logic checkData);
    int cycles;
    int expLat;
    expLat = (unit == 0) ? 2 : 5;
    applyStimulus(unit, rd, wr, addr, data, bsel);
    @(negedge clk);
    applyStimulus(unit, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    cycles = 1;
    while (!getDone(unit) && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " done"}, 32'(getDone(unit)), 32'd1);
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, " busy"}, 32'(getBusy(unit)), 32'd0);
    if (checkData) begin
      checkOutput({tag, " data"}, getData(unit), expData);
    end
  endtask

  initial begin
    logic sawDone;

    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    applyStimulus(3, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);

    // Reset state
    #12;
    checkOutput("rst busy0", 32'(busy0), 32'd0);
    checkOutput("rst done0", 32'(done0), 32'd0);
    checkOutput("rst data0", odata0, 32'h0);
    checkOutput("rst busy3", 32'(busy3), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic write with no wait states, cycle by cycle
    applyStimulus(0, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checkOutput("w35 busy e1", 32'(busy0), 32'd1);
    checkOutput("w35 done e1", 32'(done0), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("w35 done e2", 32'(done0), 32'd1);
    checkOutput("w35 busy e2", 32'(busy0), 32'd0);
    // Issued during the done cycle: back-to-back on the 0-wait instance
    runAccess(0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0, "r35", 32'hDEADBEEF, 1'b1);

    // Byte enables
    runAccess(0, 1'b0, 1'b1, 20'h5, 32'h11223344, 4'hF, "w36a", 32'h0, 1'b0);
    runAccess(0, 1'b0, 1'b1, 20'h5, 32'hAABBCCDD, 4'h5, "w36b", 32'h0, 1'b0);
    runAccess(0, 1'b1, 1'b0, 20'h5, 32'h0, 4'h0, "r36a", 32'h11BB33DD, 1'b1);
    runAccess(0, 1'b0, 1'b1, 20'h5, 32'hFFFFFFFF, 4'h0, "w36c", 32'h0, 1'b0);
    runAccess(0, 1'b1, 1'b0, 20'h5, 32'h0, 4'hF, "r36b", 32'h11BB33DD, 1'b1);

    // Write-only access leaves o_data alone
    runAccess(0, 1'b0, 1'b1, 20'h6, 32'h55667788, 4'hF, "wonly", 32'h11BB33DD, 1'b1);

    // Read and write together: read-before-write
    runAccess(0, 1'b0, 1'b1, 20'h7, 32'h00000001, 4'hF, "w38a", 32'h0, 1'b0);
    runAccess(0, 1'b1, 1'b1, 20'h7, 32'h00000002, 4'hF, "rw38", 32'h00000001, 1'b1);
    runAccess(0, 1'b1, 1'b0, 20'h7, 32'h0, 4'h0, "r38", 32'h00000002, 1'b1);

    // Three wait states: busy window, single done, ignored requests while busy
    applyStimulus(3, 1'b1, 1'b0, 20'h3, 32'h0, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) applyStimulus(3, 1'b0, 1'b1, 20'h40, 32'h99999999, 4'hF);
      else if (k == 3) applyStimulus(3, 1'b1, 1'b0, 20'h41, 32'h0, 4'h0);
      else applyStimulus(3, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
      checkOutput($sformatf("w3 busy c%0d", k), 32'(busy3), (k <= 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("w3 done c%0d", k), 32'(done3), (k == 5) ? 32'd1 : 32'd0);
    end

    // Reset aborts an in-flight write, memory survives reset
    runAccess(3, 1'b0, 1'b1, 20'h9, 32'h12345678, 4'hF, "w39a", 32'h0, 1'b0);
    runAccess(3, 1'b1, 1'b0, 20'h9, 32'h0, 4'h0, "r39a", 32'h12345678, 1'b1);
    applyStimulus(3, 1'b0, 1'b1, 20'h9, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    applyStimulus(3, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy3), 32'd0);
    checkOutput("abort done", 32'(done3), 32'd0);
    checkOutput("abort data", odata3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sawDone = sawDone | done3;
    end
    checkOutput("abort no done", 32'(sawDone), 32'd0);
    runAccess(3, 1'b1, 1'b0, 20'h9, 32'h0, 4'h0, "r39b", 32'h12345678, 1'b1);
    runAccess(0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0, "keep0", 32'hDEADBEEF, 1'b1);

    // Back-to-back on the 3-wait instance: second request held in done cycle
    runAccess(3, 1'b0, 1'b1, 20'h30, 32'hA5A5A5A5, 4'hF, "b2b w", 32'h0, 1'b0);
    runAccess(3, 1'b1, 1'b0, 20'h30, 32'h0, 4'h0, "b2b r", 32'hA5A5A5A5, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
